// File: rtl/lobinho_pkg.sv
// rtl/lobinho_pkg.sv - role codes and FSM state codes for the role drawer
package lobinho_pkg;

  // 2-bit role code stored per player in the role vector
  localparam logic [1:0] ALDEAO = 2'b00;
  localparam logic [1:0] LOBO   = 2'b01;
  localparam logic [1:0] MEDICO = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GERA   = 2'd1,
    PRONTO = 2'd2
  } estado_t;

  // Codes shown on the debug port
  localparam logic [4:0] DB_IDLE   = 5'd0;
  localparam logic [4:0] DB_GERA   = 5'd1;
  localparam logic [4:0] DB_PRONTO = 5'd2;
  localparam logic [4:0] DB_ERRO   = 5'b11111;

endpackage

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - 2-FF rising edge detector for the seed button
module edge_detector (
  input  logic clock,
  input  logic reset_n,
  input  logic entrada,
  output logic pulso
);

  logic amostra;
  logic anterior;

  // Sample the raw level, then keep the previous sample for comparison
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      amostra  <= 1'b0;
      anterior <= 1'b0;
    end else begin
      amostra  <= entrada;
      anterior <= amostra;
    end
  end

  // One-cycle pulse after a low-to-high transition has been sampled
  assign pulso = amostra & ~anterior;

endmodule

// File: rtl/sorteador_papeis.sv
// rtl/sorteador_papeis.sv - enumerates (lobo, medico) pairs and builds the role vector serially
module sorteador_papeis
  import lobinho_pkg::*;
#(
  parameter int NUM_JOGADORES = 5,
  parameter int IDX_W         = $clog2(NUM_JOGADORES)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       botao,
  input  logic                       modo_auto,
  input  logic                       sortear,
  input  logic                       limpa,
  output logic [2*NUM_JOGADORES-1:0] papeis,
  output logic                       pronto,
  output logic                       ocupado,
  output logic [IDX_W-1:0]           lobo_idx,
  output logic [IDX_W-1:0]           medico_idx,
  output logic [4:0]                 db_estado
);

  localparam int               N      = NUM_JOGADORES;
  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   N_EXT  = (IDX_W + 1)'(N);

  logic                 pulso;
  logic                 avanca;
  logic [IDX_W-1:0]     lobo;
  logic [IDX_W-1:0]     offset;
  logic [IDX_W:0]       soma;
  estado_t              estado;
  logic [IDX_W-1:0]     cap_lobo;
  logic [IDX_W-1:0]     cap_medico;
  logic [IDX_W-1:0]     jogador;
  logic [2*N-1:0]       sombra;
  logic [2*N-1:0]       sombra_prox;

  edge_detector u_borda (
    .clock   (clock),
    .reset_n (reset_n),
    .entrada (botao),
    .pulso   (pulso)
  );

  assign avanca = modo_auto | pulso;

  // Candidate counter: offset runs 1..N-1 inside each lobo, so medico never equals lobo
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lobo   <= '0;
      offset <= IDX_W'(1);
    end else if (avanca) begin
      if (offset == ULTIMO) begin
        offset <= IDX_W'(1);
        lobo   <= (lobo == ULTIMO) ? '0 : lobo + IDX_W'(1);
      end else begin
        offset <= offset + IDX_W'(1);
      end
    end
  end

  // medico = (lobo + offset) mod N, one extra bit avoids overflow before the wrap
  always_comb begin
    soma       = {1'b0, lobo} + {1'b0, offset};
    medico_idx = (soma >= N_EXT) ? IDX_W'(soma - N_EXT) : soma[IDX_W-1:0];
  end

  assign lobo_idx = lobo;

  // Shadow vector with the current player's role merged in
  always_comb begin
    sombra_prox = sombra;
    for (int p = 0; p < N; p++) begin
      if (IDX_W'(p) == jogador) begin
        if (jogador == cap_lobo)
          sombra_prox[2*(N-1-p) +: 2] = LOBO;
        else if (jogador == cap_medico)
          sombra_prox[2*(N-1-p) +: 2] = MEDICO;
        else
          sombra_prox[2*(N-1-p) +: 2] = ALDEAO;
      end
    end
  end

  // Draw FSM: capture, fill one player per cycle, publish the whole vector at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= IDLE;
      papeis     <= '0;
      sombra     <= '0;
      cap_lobo   <= '0;
      cap_medico <= '0;
      jogador    <= '0;
    end else if (limpa) begin
      estado  <= IDLE;
      papeis  <= '0;
      sombra  <= '0;
      jogador <= '0;
    end else begin
      case (estado)
        IDLE, PRONTO: begin
          if (sortear) begin
            cap_lobo   <= lobo;
            cap_medico <= medico_idx;
            jogador    <= '0;
            estado     <= GERA;
          end
        end
        GERA: begin
          sombra <= sombra_prox;
          if (jogador == ULTIMO) begin
            papeis <= sombra_prox;
            estado <= PRONTO;
          end else begin
            jogador <= jogador + IDX_W'(1);
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

  assign pronto  = (estado == PRONTO);
  assign ocupado = (estado == GERA);

  // Debug view of the state register
  always_comb begin
    case (estado)
      IDLE:    db_estado = DB_IDLE;
      GERA:    db_estado = DB_GERA;
      PRONTO:  db_estado = DB_PRONTO;
      default: db_estado = DB_ERRO;
    endcase
  end

endmodule
